// File: rtl/ospfb_fifo_read_sched.sv
// Read scheduler between an input FIFO and an oversampled PFB front end: reads DEC_FAC
// samples per FFT_LEN-cycle window and flags the remaining cycles as hold (resample) cycles.
module ospfb_fifo_read_sched #(
   parameter int unsigned FFT_LEN     = 32,
   parameter int unsigned DEC_FAC     = 24,
   parameter int unsigned SRT_PHA     = DEC_FAC - 1,
   parameter int unsigned TDATA_WIDTH = 16,
   parameter int unsigned ERR_CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   prog_empty,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   hold,
   output logic                   running,
   output logic                   underflow,
   output logic [ERR_CNT_W-1:0]   uflow_cnt
);

   localparam int unsigned PHA_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
   localparam logic [PHA_W-1:0] PHA_LAST = PHA_W'(FFT_LEN - 1);
   localparam logic [PHA_W-1:0] PHA_SRT  = PHA_W'(SRT_PHA);
   // One extra bit so DEC_FAC == FFT_LEN compares correctly.
   localparam logic [PHA_W:0]   DEC_LIM  = (PHA_W + 1)'(DEC_FAC);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPrefill = 2'd1,
      StRun     = 2'd2,
      StFault   = 2'd3
   } state_e;

   state_e                 r_state, w_state_d;
   logic [PHA_W-1:0]       r_phase, w_phase_d;
   logic [TDATA_WIDTH-1:0] r_tdata, w_tdata_d;
   logic                   r_tvalid, w_tvalid_d;
   logic                   r_hold, w_hold_d;
   logic                   r_underflow, w_underflow_d;
   logic [ERR_CNT_W-1:0]   r_cnt, w_cnt_d;

   logic w_run;
   logic w_in_window;
   logic w_read;
   logic w_uflow;

   assign w_run       = (r_state == StRun);
   assign w_in_window = ({1'b0, r_phase} < DEC_LIM);
   assign w_read      = w_run && w_in_window;
   assign w_uflow     = w_read && !s_axis_tvalid;

   always_comb begin
      w_state_d = r_state;
      w_phase_d = r_phase;
      unique case (r_state)
         StIdle: begin
            if (en) w_state_d = StPrefill;
         end
         StPrefill: begin
            if (!prog_empty) begin
               w_state_d = StRun;
               w_phase_d = PHA_SRT;
            end
         end
         StRun: begin
            w_phase_d = (r_phase == PHA_LAST) ? '0 : r_phase + 1'b1;
            if (w_uflow) w_state_d = StFault;
         end
         StFault: begin
            w_state_d = StFault;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
      if (!en) begin
         w_state_d = StIdle;
         w_phase_d = '0;
      end
   end

   always_comb begin
      w_tvalid_d = en && w_read && s_axis_tvalid;
      w_hold_d   = en && w_run && !w_in_window;
      w_tdata_d  = r_tdata;
      if (!en) begin
         w_tdata_d = '0;
      end else if (w_read && s_axis_tvalid) begin
         w_tdata_d = s_axis_tdata;
      end
      w_underflow_d = r_underflow || w_uflow;
      if (!en || (r_state == StIdle)) w_underflow_d = 1'b0;
      // Counter survives en=0 and still counts an underflow coincident with it.
      w_cnt_d = r_cnt;
      if (w_uflow && (r_cnt != '1)) w_cnt_d = r_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= StIdle;
         r_phase     <= '0;
         r_tdata     <= '0;
         r_tvalid    <= 1'b0;
         r_hold      <= 1'b0;
         r_underflow <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_d;
         r_phase     <= w_phase_d;
         r_tdata     <= w_tdata_d;
         r_tvalid    <= w_tvalid_d;
         r_hold      <= w_hold_d;
         r_underflow <= w_underflow_d;
         r_cnt       <= w_cnt_d;
      end
   end

   assign s_axis_tready = w_read;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign hold          = r_hold;
   assign running       = w_run;
   assign underflow     = r_underflow;
   assign uflow_cnt     = r_cnt;

endmodule

// File: tb/tb_ospfb_fifo_read_sched.sv
// Directed bench for ospfb_fifo_read_sched: default build, a DEC_FAC==FFT_LEN build and a
// narrow-counter build, all on one clock.
module tb_ospfb_fifo_read_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Default build
   logic        a_rstn, a_en, a_pe, a_tvalid, a_tready, a_mvalid, a_hold, a_running, a_uflow;
   logic [15:0] a_tdata, a_mdata, a_cnt;
   // DEC_FAC == FFT_LEN == 16
   logic        b_rstn, b_en, b_pe, b_tvalid, b_tready, b_mvalid, b_hold, b_running, b_uflow;
   logic [15:0] b_tdata, b_mdata, b_cnt;
   // ERR_CNT_W == 2
   logic        c_rstn, c_en, c_pe, c_tvalid, c_tready, c_mvalid, c_hold, c_running, c_uflow;
   logic [15:0] c_tdata, c_mdata;
   logic [1:0]  c_cnt;

   ospfb_fifo_read_sched u_dut_a (
      .clk(clk), .rstn(a_rstn), .en(a_en), .prog_empty(a_pe),
      .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
      .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .hold(a_hold),
      .running(a_running), .underflow(a_uflow), .uflow_cnt(a_cnt)
   );

   ospfb_fifo_read_sched #(.FFT_LEN(16), .DEC_FAC(16)) u_dut_b (
      .clk(clk), .rstn(b_rstn), .en(b_en), .prog_empty(b_pe),
      .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
      .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .hold(b_hold),
      .running(b_running), .underflow(b_uflow), .uflow_cnt(b_cnt)
   );

   ospfb_fifo_read_sched #(.ERR_CNT_W(2)) u_dut_c (
      .clk(clk), .rstn(c_rstn), .en(c_en), .prog_empty(c_pe),
      .s_axis_tdata(c_tdata), .s_axis_tvalid(c_tvalid), .s_axis_tready(c_tready),
      .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .hold(c_hold),
      .running(c_running), .underflow(c_uflow), .uflow_cnt(c_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int          ph;
   int          nvalid;
   logic        exp_rd, exp_mv, exp_hold;
   logic [15:0] exp_data;

   initial begin
      a_rstn = 1'b0; a_en = 1'b0; a_pe = 1'b1; a_tvalid = 1'b1; a_tdata = 16'h0;
      b_rstn = 1'b0; b_en = 1'b0; b_pe = 1'b0; b_tvalid = 1'b1; b_tdata = 16'h5a5a;
      c_rstn = 1'b0; c_en = 1'b0; c_pe = 1'b0; c_tvalid = 1'b0; c_tdata = 16'h0;
      #2;
      check_eq("a_rst_mdata",   32'(a_mdata),   32'h0);
      check_eq("a_rst_mvalid",  32'(a_mvalid),  32'h0);
      check_eq("a_rst_hold",    32'(a_hold),    32'h0);
      check_eq("a_rst_running", 32'(a_running), 32'h0);
      check_eq("a_rst_uflow",   32'(a_uflow),   32'h0);
      check_eq("a_rst_cnt",     32'(a_cnt),     32'h0);
      check_eq("a_rst_tready",  32'(a_tready),  32'h0);
      check_eq("c_rst_cnt",     32'(c_cnt),     32'h0);
      a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1;
      a_en = 1'b1; b_en = 1'b1;

      // prog_empty held high: never leaves PREFILL
      step();
      for (int i = 0; i < 100; i++) begin
         check_eq("a_pe_tready",  32'(a_tready),  32'h0);
         check_eq("a_pe_running", 32'(a_running), 32'h0);
         step();
      end

      // Prefill done: window starts at phase 23
      a_pe = 1'b0;
      step();
      ph = 23; exp_mv = 1'b0; exp_hold = 1'b0; exp_data = 16'h0; nvalid = 0;
      for (int c = 0; c < 64; c++) begin
         a_tdata = 16'h1000 + 16'(c);
         exp_rd = (ph < 24);
         check_eq("a_run_tready",  32'(a_tready),  32'(exp_rd));
         check_eq("a_run_running", 32'(a_running), 32'h1);
         check_eq("a_run_mvalid",  32'(a_mvalid),  32'(exp_mv));
         check_eq("a_run_hold",    32'(a_hold),    32'(exp_hold));
         if (exp_mv) check_eq("a_run_mdata", 32'(a_mdata), 32'(exp_data));
         if (c >= 1 && c <= 32 && a_mvalid) nvalid++;
         exp_mv   = exp_rd;
         exp_hold = !exp_rd;
         if (exp_rd) exp_data = a_tdata;
         ph = (ph + 1) % 32;
         step();
      end
      check_eq("a_valid_per_win", 32'(nvalid), 32'd24);

      // Underflow on a read cycle (phase 23)
      check_eq("a_uf_precond", 32'(a_tready), 32'h1);
      a_tvalid = 1'b0;
      step();
      a_tvalid = 1'b1;
      check_eq("a_uf_flag",    32'(a_uflow),   32'h1);
      check_eq("a_uf_cnt",     32'(a_cnt),     32'h1);
      check_eq("a_uf_running", 32'(a_running), 32'h0);
      check_eq("a_uf_mvalid",  32'(a_mvalid),  32'h0);
      check_eq("a_uf_hold",    32'(a_hold),    32'h0);
      check_eq("a_uf_mdata",   32'(a_mdata),   32'(exp_data));
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("a_fault_tready",  32'(a_tready),  32'h0);
         check_eq("a_fault_running", 32'(a_running), 32'h0);
         check_eq("a_fault_mvalid",  32'(a_mvalid),  32'h0);
         check_eq("a_fault_uflow",   32'(a_uflow),   32'h1);
      end
      a_en = 1'b0;
      step();
      check_eq("a_idle_uflow", 32'(a_uflow), 32'h0);
      check_eq("a_idle_cnt",   32'(a_cnt),   32'h1);
      check_eq("a_idle_mdata", 32'(a_mdata), 32'h0);
      a_en = 1'b1;
      step();
      check_eq("a_pref_running", 32'(a_running), 32'h0);
      check_eq("a_pref_cnt",     32'(a_cnt),     32'h1);
      check_eq("a_pref_uflow",   32'(a_uflow),   32'h0);
      step();
      check_eq("a_rerun_tready", 32'(a_tready), 32'h1);
      step();
      check_eq("a_rerun_hold_rd", 32'(a_tready), 32'h0);
      check_eq("a_rerun_mvalid",  32'(a_mvalid), 32'h1);
      step();
      check_eq("a_pre_rst_hold", 32'(a_hold), 32'h1);

      // Asynchronous reset mid-window
      a_rstn = 1'b0;
      #1;
      check_eq("a_arst_mdata",   32'(a_mdata),   32'h0);
      check_eq("a_arst_mvalid",  32'(a_mvalid),  32'h0);
      check_eq("a_arst_hold",    32'(a_hold),    32'h0);
      check_eq("a_arst_running", 32'(a_running), 32'h0);
      check_eq("a_arst_cnt",     32'(a_cnt),     32'h0);
      check_eq("a_arst_tready",  32'(a_tready),  32'h0);
      a_rstn = 1'b1;
      step();
      check_eq("a_resume_pref", 32'(a_running), 32'h0);
      step();
      check_eq("a_resume_run", 32'(a_running), 32'h1);
      check_eq("a_resume_rd",  32'(a_tready),  32'h1);
      step();
      check_eq("a_resume_ph24", 32'(a_tready), 32'h0);

      // DEC_FAC == FFT_LEN: every RUN cycle reads, hold never asserts
      for (int i = 0; i < 40; i++) begin
         check_eq("b_run_tready", 32'(b_tready), 32'h1);
         check_eq("b_run_mvalid", 32'(b_mvalid), 32'h1);
         check_eq("b_run_hold",   32'(b_hold),   32'h0);
         step();
      end
      b_tvalid = 1'b0;
      step();
      b_tvalid = 1'b1;
      check_eq("b_uf_flag", 32'(b_uflow), 32'h1);
      check_eq("b_uf_cnt",  32'(b_cnt),   32'h1);
      for (int i = 0; i < 3; i++) begin
         check_eq("b_fault_hold",    32'(b_hold),    32'h0);
         check_eq("b_fault_running", 32'(b_running), 32'h0);
         step();
      end

      // Narrow counter saturation; iteration 1 drops en on the underflow cycle
      for (int i = 0; i < 5; i++) begin
         c_en = 1'b1;
         step();
         step();
         check_eq("c_run_tready", 32'(c_tready), 32'h1);
         if (i == 1) c_en = 1'b0;
         step();
         check_eq("c_cnt",   32'(c_cnt),   32'((i + 1 > 3) ? 3 : i + 1));
         check_eq("c_uflow", 32'(c_uflow), 32'(i != 1));
         check_eq("c_running", 32'(c_running), 32'h0);
         c_en = 1'b0;
         step();
      end
      check_eq("c_cnt_sat", 32'(c_cnt), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
